// File: rtl/pc_addr_gen.sv
// Program counter / fetch-address generator feeding the address latch.
// Supports increment, load, relative branch and call/return through a small return stack.
module pc_addr_gen #(
  parameter int              AW      = 16,
  parameter int              DEPTH   = 4,
  parameter logic [AW-1:0]   RST_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load,
  input  logic          branch,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    offset,
  output logic [AW-1:0] pc_out,
  output logic          ale,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IDW = $clog2(DEPTH);

  logic [AW-1:0]  pc_q, pc_d;
  logic           ale_q, ale_d;
  logic           err_q, err_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [AW-1:0]  stack_d [DEPTH];

  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  pc_br;
  logic [SPW-1:0] sp_dec;
  logic [IDW-1:0] push_idx;
  logic [IDW-1:0] pop_idx;

  assign stk_full  = (sp_q == SPW'(DEPTH));
  assign stk_empty = (sp_q == '0);

  assign pc_inc   = pc_q + AW'(1);
  assign pc_br    = pc_q + {{(AW-8){offset[7]}}, offset};
  assign sp_dec   = sp_q - SPW'(1);
  assign push_idx = sp_q[IDW-1:0];
  assign pop_idx  = sp_dec[IDW-1:0];

  // Priority ret > call > load > branch > inc; a rejected ret/call consumes the cycle.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ale_d   = 1'b0;
    err_d   = 1'b0;
    stack_d = stack_q;
    if (ret) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        sp_d  = sp_dec;
        pc_d  = stack_q[pop_idx];
        ale_d = 1'b1;
      end
    end else if (call) begin
      if (stk_full) begin
        err_d = 1'b1;
      end else begin
        stack_d[push_idx] = pc_inc;
        sp_d  = sp_q + SPW'(1);
        pc_d  = load_addr;
        ale_d = 1'b1;
      end
    end else if (load) begin
      pc_d  = load_addr;
      ale_d = 1'b1;
    end else if (branch) begin
      pc_d  = pc_br;
      ale_d = 1'b1;
    end else if (inc) begin
      pc_d  = pc_inc;
      ale_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RST_VEC;
      ale_q <= 1'b0;
      err_q <= 1'b0;
      sp_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ale_q <= ale_d;
      err_q <= err_d;
      sp_q  <= sp_d;
    end
  end

  // Entries are cleared on reset so a stray read can never propagate X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign pc_out  = pc_q;
  assign ale     = ale_q;
  assign stk_err = err_q;

endmodule

// File: tb/tb_pc_addr_gen.sv
// Directed bench for pc_addr_gen with hand-computed expected values.
// A behavioural address latch downstream checks that Addout follows pc_out on ale.
module tb_pc_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc = 0, load = 0, branch = 0, call = 0, ret = 0;
  logic [15:0] load_addr = '0;
  logic [7:0]  offset = '0;
  logic [15:0] pc_out;
  logic        ale, stk_full, stk_empty, stk_err;
  logic [15:0] addout = '0;

  int n_chk  = 0;
  int n_pass = 0;

  pc_addr_gen #(.AW(16), .DEPTH(4), .RST_VEC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(load), .branch(branch),
    .call(call), .ret(ret), .load_addr(load_addr), .offset(offset),
    .pc_out(pc_out), .ale(ale), .stk_full(stk_full), .stk_empty(stk_empty),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ale) addout <= pc_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic i_inc, input logic i_load, input logic i_br,
                      input logic i_call, input logic i_ret,
                      input logic [15:0] la, input logic [7:0] off);
    inc = i_inc; load = i_load; branch = i_br; call = i_call; ret = i_ret;
    load_addr = la; offset = off;
    @(posedge clk);
    #1;
    inc = 0; load = 0; branch = 0; call = 0; ret = 0;
  endtask

  task automatic expect_st(input string tag, input logic [15:0] pc, input logic e_ale,
                           input logic e_err, input logic e_full, input logic e_empty);
    chk({tag, ".pc"},    pc_out,    pc);
    chk({tag, ".ale"},   ale,       e_ale);
    chk({tag, ".err"},   stk_err,   e_err);
    chk({tag, ".full"},  stk_full,  e_full);
    chk({tag, ".empty"}, stk_empty, e_empty);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_st("rst0", 16'h0000, 0, 0, 0, 1);

    // asynchronous reset mid-cycle discards stack and pc
    step(1, 0, 0, 0, 0, 16'h0000, 8'h00);
    step(0, 0, 0, 1, 0, 16'h0040, 8'h00);
    chk("pre_rst.empty", stk_empty, 1'b0);
    #2 rst_n = 1'b0;
    #1 expect_st("async_rst", 16'h0000, 0, 0, 0, 1);
    #3 rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00);
    expect_st("ret_after_rst", 16'h0000, 0, 1, 0, 1);

    // increments and idle
    step(1, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("inc1", 16'h0001, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("inc2", 16'h0002, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("inc3", 16'h0003, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("idle", 16'h0003, 0, 0, 0, 1);
    chk("latch_track", addout, 16'h0003);

    // load, wrap, branch both directions, load same address
    step(0, 1, 0, 0, 0, 16'hFFFF, 8'h00); expect_st("loadFFFF", 16'hFFFF, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("inc_wrap", 16'h0000, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 16'h0002, 8'h00);
    step(0, 0, 1, 0, 0, 16'h0000, 8'hFC); expect_st("br_neg", 16'hFFFE, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 16'hFFF8, 8'h00);
    step(0, 0, 1, 0, 0, 16'h0000, 8'h10); expect_st("br_pos", 16'h0008, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 16'h0008, 8'h00); expect_st("load_same", 16'h0008, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 16'h0123, 8'h05); expect_st("load_over_br", 16'h0123, 1, 0, 0, 1);

    // call / return
    step(0, 1, 0, 0, 0, 16'h0100, 8'h00);
    step(0, 0, 0, 1, 0, 16'h2000, 8'h00); expect_st("call1", 16'h2000, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 16'h3000, 8'h00); expect_st("call2", 16'h3000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); expect_st("ret1", 16'h2001, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); expect_st("ret2", 16'h0101, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1, 16'h5555, 8'h00); expect_st("ret_empty", 16'h0101, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0000, 8'h00); expect_st("err_clear", 16'h0101, 0, 0, 0, 1);

    // fill stack, overflow, LIFO drain
    step(0, 0, 0, 1, 0, 16'h1000, 8'h00);
    step(0, 0, 0, 1, 0, 16'h1100, 8'h00);
    step(0, 0, 0, 1, 0, 16'h1200, 8'h00);
    step(0, 0, 0, 1, 0, 16'h1300, 8'h00); expect_st("fill", 16'h1300, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0, 16'h4000, 8'h00); expect_st("call_full", 16'h1300, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); expect_st("pop1", 16'h1201, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); chk("pop2.pc", pc_out, 16'h1101);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); chk("pop3.pc", pc_out, 16'h1001);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); expect_st("pop4", 16'h0102, 1, 0, 0, 1);

    // all commands together
    step(1, 1, 1, 1, 1, 16'h7777, 8'h04); expect_st("all_empty", 16'h0102, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 16'h5000, 8'h00);
    step(1, 1, 1, 1, 1, 16'h7777, 8'h04); expect_st("all_ret", 16'h0103, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 16'h0000, 8'h00);
    chk("latch_all", addout, 16'h0103);

    // return address wraps when calling from FFFF
    step(0, 1, 0, 0, 0, 16'hFFFF, 8'h00);
    step(0, 0, 0, 1, 0, 16'h1234, 8'h00); chk("call_wrap.pc", pc_out, 16'h1234);
    step(0, 0, 0, 0, 1, 16'h0000, 8'h00); expect_st("ret_wrap", 16'h0000, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
